// File: rtl/brightness_pwm_gen.sv
// Display brightness PWM generator: prescaled phase counter compared against
// a duty word. Duty updates are double-buffered and applied only at period
// boundaries so a period is never cut short or glitched.
module brightness_pwm_gen #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 195
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_load,
    output logic             pwm,
    output logic             period_start,
    output logic [WIDTH-1:0] duty_active
);

    localparam int             PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] DMAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             pstart_q, pstart_d;
    logic             tick;
    logic             boundary;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: enable alone moves between IDLE and RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase step tick; boundary is the tick that wraps the phase to 0.
    // A boundary while being disabled is skipped; IDLE then applies the duty.
    assign tick     = (state_q == RUN) && (presc_q == PMAX);
    assign boundary = tick && (phase_q == DMAX) && enable;

    // Datapath next-state: counters, duty double buffer, registered outputs
    always_comb begin
        presc_d    = presc_q;
        phase_d    = phase_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        duty_d     = duty_q;
        pwm_d      = 1'b0;
        pstart_d   = 1'b0;

        // Counters are zero in IDLE and on the way out of RUN, so a fresh
        // run always starts at phase 0 without a period_start pulse.
        if (!enable || state_q == IDLE) begin
            presc_d = '0;
            phase_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) phase_d = phase_q + 1'b1;
        end

        // All-ones duty forces full on, avoiding the one-step dropout.
        if (enable) pwm_d = (phase_q < duty_q) || (duty_q == DMAX);

        pstart_d = boundary;

        // Apply pending duty immediately in IDLE, else only at the boundary.
        if (pend_vld_q && (state_q == IDLE || boundary)) begin
            duty_d     = pend_q;
            pend_vld_d = 1'b0;
        end

        // Capture last so a coincident load stays pending for the next boundary.
        if (duty_load) begin
            pend_d     = duty_in;
            pend_vld_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            phase_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            pstart_q   <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            phase_q    <= phase_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            duty_q     <= duty_d;
            pwm_q      <= pwm_d;
            pstart_q   <= pstart_d;
        end
    end

    assign pwm          = pwm_q;
    assign period_start = pstart_q;
    assign duty_active  = duty_q;

endmodule

// File: tb/tb_brightness_pwm_gen.sv
// Directed bench: WIDTH=4/PRESCALE=2 instance for function, plus a
// default-parameter instance for the full-size period.
module tb_brightness_pwm_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] duty_in = '0;
    logic       duty_load = 1'b0;
    logic       pwm, period_start;
    logic [3:0] duty_active;

    logic       d_enable = 1'b0;
    logic [7:0] d_duty_in = '0;
    logic       d_duty_load = 1'b0;
    logic       d_pwm, d_period_start;
    logic [7:0] d_duty_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    brightness_pwm_gen #(.WIDTH(4), .PRESCALE(2)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
        .duty_load(duty_load), .pwm(pwm), .period_start(period_start),
        .duty_active(duty_active)
    );

    brightness_pwm_gen dut_def (
        .clk(clk), .reset_n(reset_n), .enable(d_enable), .duty_in(d_duty_in),
        .duty_load(d_duty_load), .pwm(d_pwm), .period_start(d_period_start),
        .duty_active(d_duty_active)
    );

    // Advance to the next negedge showing period_start, bounded.
    task automatic wait_ps();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 40);
        checks++;
        if (!period_start) begin
            errors++;
            $display("FAIL wait_ps: no period_start within %0d cycles", n);
        end
    endtask

    // Count pwm high and period_start pulses over the next 32 cycles.
    task automatic measure(output int hi, output int ps);
        hi = 0; ps = 0;
        repeat (32) begin
            @(negedge clk);
            if (pwm) hi++;
            if (period_start) ps++;
        end
    endtask

    task automatic load(input logic [3:0] v);
        duty_in = v; duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (pwm !== 1'b0 || period_start !== 1'b0 || duty_active !== 4'd0) begin
            errors++;
            $display("FAIL reset: pwm=%b ps=%b duty=%0d want 0 0 0", pwm, period_start, duty_active);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_duty4();
        int hi, ps;
        @(negedge clk);
        load(4'd4);
        @(negedge clk);
        checks++;
        if (duty_active !== 4'd4) begin
            errors++;
            $display("FAIL idle_apply: duty=%0d want 4", duty_active);
        end
        enable = 1'b1;
        wait_ps();
        measure(hi, ps);
        checks++;
        if (hi != 8 || ps != 1) begin
            errors++;
            $display("FAIL duty4: high=%0d ps=%0d want 8 1", hi, ps);
        end
    endtask

    task automatic test_deferred();
        int hi, ps;
        repeat (10) @(negedge clk);
        load(4'd12);
        checks++;
        if (duty_active !== 4'd4) begin
            errors++;
            $display("FAIL defer_early: duty=%0d want 4", duty_active);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (duty_active !== 4'd4 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL defer_pre: duty=%0d ps=%b want 4 0", duty_active, period_start);
        end
        @(negedge clk);
        checks++;
        if (duty_active !== 4'd12 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL defer_apply: duty=%0d ps=%b want 12 1", duty_active, period_start);
        end
        measure(hi, ps);
        checks++;
        if (hi != 24 || ps != 1) begin
            errors++;
            $display("FAIL duty12: high=%0d ps=%0d want 24 1", hi, ps);
        end
    endtask

    task automatic test_collision();
        int hi, ps;
        repeat (4) @(negedge clk);
        load(4'd5);
        repeat (26) @(negedge clk);
        duty_in = 4'd9; duty_load = 1'b1;
        @(negedge clk);
        duty_load = 1'b0;
        checks++;
        if (duty_active !== 4'd5 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL collide_old: duty=%0d ps=%b want 5 1", duty_active, period_start);
        end
        repeat (32) @(negedge clk);
        checks++;
        if (duty_active !== 4'd9 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL collide_new: duty=%0d ps=%b want 9 1", duty_active, period_start);
        end
        repeat (4) @(negedge clk);
        load(4'd3);
        repeat (7) @(negedge clk);
        load(4'd7);
        repeat (18) @(negedge clk);
        checks++;
        if (duty_active !== 4'd9) begin
            errors++;
            $display("FAIL overwrite_pre: duty=%0d want 9", duty_active);
        end
        @(negedge clk);
        checks++;
        if (duty_active !== 4'd7 || period_start !== 1'b1) begin
            errors++;
            $display("FAIL overwrite: duty=%0d ps=%b want 7 1", duty_active, period_start);
        end
        measure(hi, ps);
        checks++;
        if (hi != 14 || ps != 1 || duty_active !== 4'd7) begin
            errors++;
            $display("FAIL duty7: high=%0d ps=%0d duty=%0d want 14 1 7", hi, ps, duty_active);
        end
    endtask

    task automatic test_extremes();
        int hi, ps;
        load(4'd0);
        wait_ps();
        measure(hi, ps);
        checks++;
        if (hi != 0 || ps != 1 || duty_active !== 4'd0) begin
            errors++;
            $display("FAIL duty0: high=%0d ps=%0d duty=%0d want 0 1 0", hi, ps, duty_active);
        end
        load(4'd15);
        wait_ps();
        measure(hi, ps);
        checks++;
        if (hi != 32 || ps != 1 || duty_active !== 4'd15) begin
            errors++;
            $display("FAIL duty15: high=%0d ps=%0d duty=%0d want 32 1 15", hi, ps, duty_active);
        end
    endtask

    task automatic test_disable();
        int n;
        repeat (14) @(negedge clk);
        checks++;
        if (pwm !== 1'b1) begin
            errors++;
            $display("FAIL dis_pre: pwm=%b want 1", pwm);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm !== 1'b0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL disable: pwm=%b ps=%b want 0 0", pwm, period_start);
        end
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 40);
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL restart_phase: first ps after %0d cycles want 33", n);
        end
    endtask

    task automatic test_reset_mid();
        repeat (14) @(negedge clk);
        load(4'd4);
        checks++;
        if (pwm !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: pwm=%b want 1", pwm);
        end
        reset_n = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if (pwm !== 1'b0 || period_start !== 1'b0 || duty_active !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: pwm=%b ps=%b duty=%0d want 0 0 0", pwm, period_start, duty_active);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (duty_active !== 4'd0 || pwm !== 1'b0) begin
            errors++;
            $display("FAIL rst_pending_lost: duty=%0d pwm=%b want 0 0", duty_active, pwm);
        end
    endtask

    task automatic test_defaults();
        int n, hi;
        @(negedge clk);
        d_duty_in = 8'd128; d_duty_load = 1'b1;
        @(negedge clk);
        d_duty_load = 1'b0;
        @(negedge clk);
        checks++;
        if (d_duty_active !== 8'd128) begin
            errors++;
            $display("FAIL def_apply: duty=%0d want 128", d_duty_active);
        end
        d_enable = 1'b1;
        n = 0; hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (n >= 2 && d_pwm) hi++;
        end while (!d_period_start && n < 60000);
        checks++;
        if (n != 49921 || hi != 24960) begin
            errors++;
            $display("FAIL def_period: period=%0d high=%0d want 49921 24960", n, hi);
        end
    endtask

    initial begin
        test_reset();
        test_duty4();
        test_deferred();
        test_collision();
        test_extremes();
        test_disable();
        test_reset_mid();
        test_defaults();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
